// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-bit-addressed register port to fabric logic.
// SDA is open-drain: sda_enable=1 pulls the line low, 0 releases it.
module i2c_target_regs #(
    parameter logic [6:0] DEVICE_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_enable,
    output logic       busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_ADDR, S_REG_ADDR, S_WRITE,
        S_ACK_W, S_READ, S_MACK, S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_sync_q, sda_sync_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic        sda_en_q, sda_en_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic        ld_q, ld_d;

    logic       scl, scl_prev, sda, sda_prev;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;

    // [1] is the synchronized level, [2] its one-cycle history for edge detection
    assign scl      = scl_sync_q[1];
    assign scl_prev = scl_sync_q[2];
    assign sda      = sda_sync_q[1];
    assign sda_prev = sda_sync_q[2];

    assign scl_rise  = scl & ~scl_prev;
    assign scl_fall  = ~scl & scl_prev;
    assign start_det = scl & scl_prev & sda_prev & ~sda;
    assign stop_det  = scl & scl_prev & ~sda_prev & sda;
    assign byte_in   = {shift_q[6:0], sda};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        ptr_d    = ptr_q;
        wdata_d  = wdata_q;
        rw_d     = rw_q;
        sda_en_d = sda_en_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        ld_d     = re_q;

        // pointer advances right after the write strobe so reg_addr is stable with it
        if (we_q) ptr_d = ptr_q + 8'd1;
        if (ld_q) tx_d = reg_rdata;

        if (start_det) begin
            sda_en_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = S_ADDR;
        end else if (stop_det) begin
            sda_en_d = 1'b0;
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (byte_in[7:1] != DEVICE_ADDR) begin
                                state_d = S_IDLE;
                            end else begin
                                rw_d = byte_in[0];
                                re_d = byte_in[0];
                            end
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_en_d = 1'b1;
                        state_d  = S_ACK_ADDR;
                    end
                end
                S_ACK_ADDR: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            sda_en_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b1};
                            cnt_d    = 4'd1;
                            state_d  = S_READ;
                        end else begin
                            sda_en_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = S_REG_ADDR;
                        end
                    end
                end
                S_REG_ADDR: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) ptr_d = byte_in;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_en_d = 1'b1;
                        state_d  = S_ACK_W;
                    end
                end
                S_WRITE: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            we_d    = 1'b1;
                            wdata_d = byte_in;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_en_d = 1'b1;
                        state_d  = S_ACK_W;
                    end
                end
                S_ACK_W: begin
                    if (scl_fall) begin
                        sda_en_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = S_WRITE;
                    end
                end
                S_READ: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_en_d = 1'b0;
                            ptr_d    = ptr_q + 8'd1;
                            state_d  = S_MACK;
                        end else begin
                            sda_en_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b1};
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                S_MACK: begin
                    if (scl_rise) begin
                        if (!sda) begin
                            re_d    = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = S_READ;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            ptr_q      <= 8'h00;
            wdata_q    <= 8'h00;
            rw_q       <= 1'b0;
            sda_en_q   <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            ld_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= {scl_sync_q[1:0], scl_in};
            sda_sync_q <= {sda_sync_q[1:0], sda_in};
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            sda_en_q   <= sda_en_d;
            we_q       <= we_d;
            re_q       <= re_d;
            ld_q       <= ld_d;
        end
    end

    assign sda_enable = sda_en_q;
    assign busy       = (state_q != S_IDLE);
    assign reg_addr   = ptr_q;
    assign reg_wdata  = wdata_q;
    assign reg_we     = we_q;
    assign reg_re     = re_q;

endmodule
